// File: rtl/seq_pkg.sv
// Shared types and constants for the serial test-link transmitter.
package seq_pkg;

    // Main transmit FSM
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } gen_state_t;

    // Golden-model tracker for the 01[0*]1 pattern
    typedef enum logic [1:0] {
        T_IDLE     = 2'd0,
        T_ZERO     = 2'd1,
        T_ZERO_ONE = 2'd2
    } trk_state_t;

    // Saturation point, matching the two-digit display on the detector side
    localparam int unsigned CNT_MAX = 99;

endpackage

// File: rtl/pattern_tracker.sv
// Golden model of the detector: counts non-overlapping 01[0*]1 matches in
// the transmitted bit stream with a counter that saturates at CNT_MAX.
// Ports:
//   clk, rst  - clock, async active-low reset
//   clear     - restart tracking and zero the count (frame start)
//   step      - consume bit_in this cycle
//   bit_in    - serial bit being transmitted
//   count     - registered match count
module pattern_tracker
    import seq_pkg::*;
#(
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  logic             bit_in,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(CNT_MAX);

    trk_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    // State and count registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= T_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state: Mealy match on the third transition, counter never wraps
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (clear) begin
            state_d = T_IDLE;
            count_d = '0;
        end else if (step) begin
            case (state_q)
                T_IDLE:     if (!bit_in) state_d = T_ZERO;
                T_ZERO:     if (bit_in)  state_d = T_ZERO_ONE;
                T_ZERO_ONE: begin
                    if (bit_in) begin
                        state_d = T_IDLE;
                        if (count_q < SAT) count_d = count_q + CNT_W'(1);
                    end
                end
                default:    state_d = T_IDLE;
            endcase
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sequence_generator.sv
// Transmit side of the serial test link: accepts a parallel pattern on load,
// shifts it out LSB first one bit per enabled clock, and reports the number
// of 01[0*]1 matches the detector should see in that frame.
// Ports:
//   clk, rst        - clock, async active-low reset
//   ena             - advance enable while shifting
//   load, pattern   - frame request and frame bits (pattern[0] sent first)
//   busy            - frame in progress (SHIFT or DONE)
//   sig_out         - serial bit, valid while sig_valid
//   sig_valid       - high during SHIFT
//   done            - one-cycle pulse after the last bit is consumed
//   expected_count  - golden match count for current/last frame
module sequence_generator
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern,
    output logic             busy,
    output logic             sig_out,
    output logic             sig_valid,
    output logic             done,
    output logic [CNT_W-1:0] expected_count
);

    localparam int unsigned BCW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0] LAST = BCW'(WIDTH - 1);

    gen_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic             sig_out_q, sig_out_d;
    logic             sig_valid_q, sig_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept_c;
    logic             consume_c;

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            sig_out_q   <= 1'b0;
            sig_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            sig_out_q   <= sig_out_d;
            sig_valid_q <= sig_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign accept_c  = (state_q == IDLE) && load;
    assign consume_c = (state_q == SHIFT) && ena;

    // Next-state logic; sig_out is pre-loaded with the bit that the next
    // consuming edge will see, so it is stable for the whole bit period.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        sig_out_d = sig_out_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d   = SHIFT;
                    shreg_d   = pattern;
                    bitcnt_d  = '0;
                    sig_out_d = pattern[0];
                end
            end
            SHIFT: begin
                if (ena) begin
                    shreg_d   = shreg_q >> 1;
                    bitcnt_d  = bitcnt_q + BCW'(1);
                    sig_out_d = shreg_q[1];
                    if (bitcnt_q == LAST) begin
                        state_d   = DONE;
                        bitcnt_d  = '0;
                        sig_out_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                sig_out_d = 1'b0;
            end
        endcase
        sig_valid_d = (state_d == SHIFT);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    pattern_tracker #(
        .CNT_W (CNT_W)
    ) u_tracker (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept_c),
        .step   (consume_c),
        .bit_in (sig_out_q),
        .count  (expected_count)
    );

    assign busy      = busy_q;
    assign sig_out   = sig_out_q;
    assign sig_valid = sig_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: the driver pushes expected bits
// and final counts, a negedge monitor pops and compares them.
module tb_sequence_generator;

    localparam int W  = 24;
    localparam int BW = 512;
    localparam int CW = 7;
    localparam logic [W-1:0] NOM = 24'b110010101110100011001000;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena, load;
    logic [W-1:0]  pattern;
    logic          busy, sig_out, sig_valid, done;
    logic [CW-1:0] expected_count;

    logic          ena_b, load_b;
    logic [BW-1:0] pattern_b;
    logic          busy_b, sig_out_b, sig_valid_b, done_b;
    logic [CW-1:0] expected_count_b;

    int vectors = 0;
    int miscompares = 0;
    logic bitq[$];
    int   cntq[$];

    logic [W-1:0]  rpat;
    logic [BW-1:0] bpat;
    int            bcyc;

    always #5 clk = ~clk;

    sequence_generator #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .ena(ena), .load(load), .pattern(pattern),
        .busy(busy), .sig_out(sig_out), .sig_valid(sig_valid), .done(done),
        .expected_count(expected_count)
    );

    sequence_generator #(.WIDTH(BW), .CNT_W(CW)) dut_big (
        .clk(clk), .rst(rst), .ena(ena_b), .load(load_b), .pattern(pattern_b),
        .busy(busy_b), .sig_out(sig_out_b), .sig_valid(sig_valid_b), .done(done_b),
        .expected_count(expected_count_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference: scan the first n bits for "0, then 1, then 1" with zeros
    // allowed between; each found triple is one match, scanning resumes after it.
    function automatic int model_count(input logic [BW-1:0] p, input int n);
        int c;
        int i;
        c = 0;
        i = 0;
        while (i < n) begin
            while (i < n && p[i] == 1'b1) i++;
            if (i >= n) break;
            i++;
            while (i < n && p[i] == 1'b0) i++;
            if (i >= n) break;
            i++;
            while (i < n && p[i] == 1'b0) i++;
            if (i >= n) break;
            i++;
            c++;
        end
        return (c > 99) ? 99 : c;
    endfunction

    // Monitor: compares serial bits while valid, final count on done
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (sig_valid) begin
                if (bitq.size() == 0) fail("sig_out_unexpected");
                else begin
                    check("sig_out", 32'(sig_out), 32'(bitq[0]));
                    if (ena) void'(bitq.pop_front());
                end
            end
            if (done) begin
                if (cntq.size() == 0) fail("done_unexpected");
                else check("count_at_done", 32'(expected_count), cntq.pop_front());
            end
        end
    end

    task automatic run_frame(input logic [W-1:0] pat, input int stall_at, input int stall_len,
                             input int busy_load_at, input bit rand_ena);
        int consumed;
        int stall_left;
        int guard;
        bit e;
        consumed   = 0;
        guard      = 0;
        stall_left = stall_len;
        for (int i = 0; i < W; i++) bitq.push_back(pat[i]);
        cntq.push_back(model_count(BW'(pat), W));
        pattern = pat;
        load    = 1'b1;
        ena     = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        load = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("count_cleared", 32'(expected_count), 32'd0);
        while (consumed < W && guard < 8 * W) begin
            if (consumed == stall_at && stall_left > 0) begin
                e = 1'b0;
                stall_left--;
            end else if (rand_ena) e = ($urandom_range(0, 3) != 0);
            else e = 1'b1;
            ena = e;
            if (consumed == busy_load_at) begin
                load    = 1'b1;
                pattern = ~pat;
            end
            @(posedge clk); #1;
            load    = 1'b0;
            pattern = pat;
            if (e) consumed++;
            guard++;
            check("running_count", 32'(expected_count), model_count(BW'(pat), consumed));
            if (consumed < W) check("done_early", 32'(done), 32'd0);
        end
        if (consumed < W) fail("frame_timeout");
        check("done_pulse", 32'(done), 32'd1);
        check("sig_valid_in_done", 32'(sig_valid), 32'd0);
        check("busy_in_done", 32'(busy), 32'd1);
        ena = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("count_hold", 32'(expected_count), model_count(BW'(pat), W));
    endtask

    task automatic reset_mid_frame();
        pattern = NOM;
        load    = 1'b1;
        ena     = 1'b1;
        bitq.delete();
        cntq.delete();
        for (int i = 0; i < W; i++) bitq.push_back(NOM[i]);
        @(posedge clk); #1;
        load = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("pre_reset_count", 32'(expected_count), model_count(BW'(NOM), 15));
        #2 rst = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_valid", 32'(sig_valid), 32'd0);
        check("async_rst_count", 32'(expected_count), 32'd0);
        check("async_rst_sig_out", 32'(sig_out), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        bitq.delete();
        cntq.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        ena = 1'b0;
        @(posedge clk); #1;
        check("post_rst_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_big(input logic [BW-1:0] pat);
        pattern_b = pat;
        load_b    = 1'b1;
        ena_b     = 1'b1;
        @(posedge clk); #1;
        load_b = 1'b0;
        bcyc   = 0;
        while (!done_b && bcyc < BW + 20) begin
            @(posedge clk); #1;
            bcyc++;
            if (bcyc <= BW) check("big_running_count", 32'(expected_count_b), model_count(pat, bcyc));
        end
        check("big_done", 32'(done_b), 32'd1);
        check("big_count_at_done", 32'(expected_count_b), model_count(pat, BW));
        @(posedge clk); #1;
        check("big_idle", 32'(busy_b), 32'd0);
        check("big_count_hold", 32'(expected_count_b), model_count(pat, BW));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        ena       = 1'b0;
        load      = 1'b0;
        pattern   = '0;
        ena_b     = 1'b0;
        load_b    = 1'b0;
        pattern_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sig_out", 32'(sig_out), 32'd0);
        check("rst_valid", 32'(sig_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(expected_count), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_sig_out", 32'(sig_out), 32'd0);
        check("idle_valid", 32'(sig_valid), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_count", 32'(expected_count), 32'd0);

        run_frame(NOM, -1, 0, -1, 1'b0);
        run_frame(24'h000000, -1, 0, -1, 1'b0);
        run_frame(24'hFFFFFF, -1, 0, -1, 1'b0);
        run_frame(24'hAAAAAA, -1, 0, -1, 1'b0);
        run_frame(24'hFFFFFE, -1, 0, -1, 1'b0);
        run_frame(NOM, 11, 3, -1, 1'b0);
        run_frame(NOM, -1, 0, 5, 1'b0);
        run_frame(24'h5A3C96, -1, 0, -1, 1'b0);

        reset_mid_frame();

        repeat (20) begin
            rpat = W'($urandom);
            run_frame(rpat, int'($urandom_range(0, W - 1)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, W - 1)), 1'b1);
        end

        for (int i = 0; i < BW; i++) bpat[i] = ((i % 3) != 0);
        run_big(bpat);
        for (int i = 0; i < BW / 32; i++) bpat[i*32 +: 32] = $urandom;
        run_big(bpat);

        if (bitq.size() != 0 || cntq.size() != 0) fail("scoreboard_leftover");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
